// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory port controller between the pipeline memory stage and a
// variable-latency req/ack data bus.
//
// Optional feature: define DMEM_WBUF_EN to enable a one-entry posted-write buffer.
// A write arriving while the buffer is empty then retires in the next cycle and
// drains on the bus in the background.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   rw_flag               0/3 idle, 1 read, 2 write
//   addr, write_data      word address and byte-lane-aligned store data
//   write_mask            byte enables, bit0 = byte [7:0]
//   read_data             last completed read word
//   mem_busy              request cannot be accepted this cycle (registered state only)
//   mem_done              one-cycle completion pulse per accepted request
//   ext_req/we/addr/wdata/wmask  registered bus request, held until ack
//   ext_ack, ext_rdata    bus completion and read data

module dmem_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  rw_flag,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_mask,
   output logic [31:0] read_data,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        ext_req,
   output logic        ext_we,
   output logic [31:0] ext_addr,
   output logic [31:0] ext_wdata,
   output logic [3:0]  ext_wmask,
   input  logic        ext_ack,
   input  logic [31:0] ext_rdata
);

   typedef enum logic [1:0] {StIdle, StWait, StBus, StDone} state_e;

   state_e      state_q, state_d;

   // Main slot: holds a request while it waits for the write buffer to drain.
   logic        slot_we_q, slot_we_d;
   logic [31:0] slot_addr_q, slot_addr_d;
   logic [31:0] slot_wdata_q, slot_wdata_d;
   logic [3:0]  slot_wmask_q, slot_wmask_d;

   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;

   // Bus registers. While the write buffer is valid they hold the buffered write,
   // so the buffer needs no storage of its own beyond the valid flag.
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] eaddr_q, eaddr_d;
   logic [31:0] ewdata_q, ewdata_d;
   logic [3:0]  ewmask_q, ewmask_d;
   logic        wb_valid_q, wb_valid_d;

   logic        busy;
   logic        is_write;
   logic        accept;
   logic        to_buf;

   assign busy     = (state_q == StWait) || (state_q == StBus);
   assign is_write = (rw_flag == 2'd2);
   assign accept   = !busy && ((rw_flag == 2'd1) || (rw_flag == 2'd2));

`ifdef DMEM_WBUF_EN
   assign to_buf = is_write && !wb_valid_q;
`else
   assign to_buf = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      slot_we_d    = slot_we_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      slot_wmask_d = slot_wmask_q;
      rdata_d      = rdata_q;
      done_d       = 1'b0;
      req_d        = req_q;
      we_d         = we_q;
      eaddr_d      = eaddr_q;
      ewdata_d     = ewdata_q;
      ewmask_d     = ewmask_q;
      wb_valid_d   = wb_valid_q;

      // The buffered write retires on its own ack, independent of the main slot.
      if (wb_valid_q && req_q && ext_ack) begin
         wb_valid_d = 1'b0;
         req_d      = 1'b0;
      end

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               if (to_buf) begin
                  // Posted write: complete to the stage now, drain on the bus later.
                  wb_valid_d = 1'b1;
                  req_d      = 1'b1;
                  we_d       = 1'b1;
                  eaddr_d    = addr;
                  ewdata_d   = write_data;
                  ewmask_d   = write_mask;
                  done_d     = 1'b1;
               end else begin
                  slot_we_d    = is_write;
                  slot_addr_d  = addr;
                  slot_wdata_d = write_data;
                  slot_wmask_d = write_mask;
                  if (wb_valid_q) begin
                     // Keep program order behind the pending buffered write.
                     state_d = StWait;
                  end else begin
                     state_d  = StBus;
                     req_d    = 1'b1;
                     we_d     = is_write;
                     eaddr_d  = addr;
                     ewdata_d = write_data;
                     ewmask_d = write_mask;
                  end
               end
            end
         end
         StWait: begin
            // wb_valid_q drops the cycle after the buffer ack, so ext_req has its
            // mandatory low cycle before the slot's transfer starts.
            if (!wb_valid_q) begin
               state_d  = StBus;
               req_d    = 1'b1;
               we_d     = slot_we_q;
               eaddr_d  = slot_addr_q;
               ewdata_d = slot_wdata_q;
               ewmask_d = slot_wmask_q;
            end
         end
         StBus: begin
            if (ext_ack) begin
               state_d = StDone;
               req_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  rdata_d = ext_rdata;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         slot_we_q    <= 1'b0;
         slot_addr_q  <= 32'd0;
         slot_wdata_q <= 32'd0;
         slot_wmask_q <= 4'd0;
         rdata_q      <= 32'd0;
         done_q       <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         eaddr_q      <= 32'd0;
         ewdata_q     <= 32'd0;
         ewmask_q     <= 4'd0;
         wb_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_we_q    <= slot_we_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         slot_wmask_q <= slot_wmask_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         req_q        <= req_d;
         we_q         <= we_d;
         eaddr_q      <= eaddr_d;
         ewdata_q     <= ewdata_d;
         ewmask_q     <= ewmask_d;
         wb_valid_q   <= wb_valid_d;
      end
   end

   assign read_data = rdata_q;
   assign mem_busy  = busy;
   assign mem_done  = done_q;
   assign ext_req   = req_q;
   assign ext_we    = we_q;
   assign ext_addr  = eaddr_q;
   assign ext_wdata = ewdata_q;
   assign ext_wmask = ewmask_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed timing scenarios followed by randomized requests checked
// against a program-order memory model. Define DMEM_WBUF_EN to match the DUT build.

module tb_dmem_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  rw_flag;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic [31:0] read_data;
   logic        mem_busy;
   logic        mem_done;
   logic        ext_req;
   logic        ext_we;
   logic [31:0] ext_addr;
   logic [31:0] ext_wdata;
   logic [3:0]  ext_wmask;
   logic        ext_ack;
   logic [31:0] ext_rdata;

`ifdef DMEM_WBUF_EN
   localparam bit Wbuf = 1'b1;
`else
   localparam bit Wbuf = 1'b0;
`endif

   dmem_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .rw_flag    (rw_flag),
      .addr       (addr),
      .write_data (write_data),
      .write_mask (write_mask),
      .read_data  (read_data),
      .mem_busy   (mem_busy),
      .mem_done   (mem_done),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_wmask  (ext_wmask),
      .ext_ack    (ext_ack),
      .ext_rdata  (ext_rdata)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   bit          auto_ack = 1'b0;
   logic [31:0] bus_mem  [logic [31:0]];
   logic [31:0] gold_mem [logic [31:0]];

   // Responder state
   bit          r_acked = 1'b0;
   bit          r_busy  = 1'b0;
   int          r_wait  = 0;
   logic        h_we;
   logic [31:0] h_addr;
   logic [31:0] h_wdata;
   logic [3:0]  h_wmask;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] rd_bus(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rd_gold(input logic [31:0] a);
      return gold_mem.exists(a) ? gold_mem[a] : init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_busy"}, mem_busy, 1'b0);
      chk1({tag, "_done"}, mem_done, 1'b0);
      chk({tag, "_rdata"}, read_data, 32'd0);
      chk1({tag, "_req"}, ext_req, 1'b0);
      chk1({tag, "_we"}, ext_we, 1'b0);
      chk({tag, "_addr"}, ext_addr, 32'd0);
      chk({tag, "_wdata"}, ext_wdata, 32'd0);
      chk({tag, "_wmask"}, {28'd0, ext_wmask}, 32'd0);
   endtask

   // Bus responder for the randomized phase: random wait states, memory-backed data,
   // and protocol checks on hold stability and the post-ack idle cycle.
   initial begin : responder
      forever begin
         @(negedge CLK);
         if (auto_ack) begin
            if (r_acked) begin
               chk1("bus_req_gap", ext_req, 1'b0);
               r_acked = 1'b0;
               ext_ack = 1'b0;
            end else if (ext_req) begin
               if (!r_busy) begin
                  r_busy  = 1'b1;
                  h_we    = ext_we;
                  h_addr  = ext_addr;
                  h_wdata = ext_wdata;
                  h_wmask = ext_wmask;
                  r_wait  = $urandom_range(0, 3);
               end else begin
                  chk("bus_hold_addr", ext_addr, h_addr);
                  chk("bus_hold_wdata", ext_wdata, h_wdata);
                  chk("bus_hold_ctl", {27'd0, ext_we, ext_wmask}, {27'd0, h_we, h_wmask});
               end
               if (r_wait == 0) begin
                  ext_ack = 1'b1;
                  r_acked = 1'b1;
                  r_busy  = 1'b0;
                  if (ext_we) bus_mem[ext_addr] = merge(rd_bus(ext_addr), ext_wdata, ext_wmask);
                  else ext_rdata = rd_bus(ext_addr);
               end else begin
                  r_wait--;
                  ext_ack = 1'b0;
               end
            end else begin
               ext_ack = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] exp_rd;
      logic [31:0] a, d;
      logic [3:0]  m;
      bit          wr;
      int          k;

      RST        = 1'b1;
      rw_flag    = 2'd0;
      addr       = 32'd0;
      write_data = 32'd0;
      write_mask = 4'd0;
      ext_ack    = 1'b0;
      ext_rdata  = 32'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_reset_outputs("rst");
      RST = 1'b0;

      // Read 0x100, ack in the first BUS cycle
      @(negedge CLK);
      rw_flag = 2'd1; addr = 32'h100;
      @(posedge CLK); #1;
      rw_flag = 2'd0; ext_ack = 1'b1; ext_rdata = 32'hDEADBEEF;
      @(negedge CLK);
      chk1("t1_req_c1", ext_req, 1'b1);
      chk1("t1_we_c1", ext_we, 1'b0);
      chk("t1_addr_c1", ext_addr, 32'h100);
      chk1("t1_busy_c1", mem_busy, 1'b1);
      chk1("t1_done_c1", mem_done, 1'b0);
      @(posedge CLK); #1;
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t1_done_c2", mem_done, 1'b1);
      chk("t1_rdata_c2", read_data, 32'hDEADBEEF);
      chk1("t1_busy_c2", mem_busy, 1'b0);
      chk1("t1_req_c2", ext_req, 1'b0);
      @(negedge CLK);
      chk1("t1_done_c3", mem_done, 1'b0);

      // Write 0xAB to 0x204 mask 0001, ack in the fourth request cycle
      @(negedge CLK);
      rw_flag = 2'd2; addr = 32'h204; write_data = 32'h0000_00AB; write_mask = 4'b0001;
      @(posedge CLK); #1;
      rw_flag = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         ext_ack = (i == 4);
         @(negedge CLK);
         chk1("t2_req", ext_req, 1'b1);
         chk1("t2_we", ext_we, 1'b1);
         chk("t2_addr", ext_addr, 32'h204);
         chk("t2_wdata", ext_wdata, 32'h0000_00AB);
         chk("t2_wmask", {28'd0, ext_wmask}, 32'd1);
         chk1("t2_busy", mem_busy, !Wbuf);
         chk1("t2_done", mem_done, Wbuf && (i == 1));
         chk("t2_rdata", read_data, 32'hDEADBEEF);
         @(posedge CLK); #1;
      end
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t2_req_after", ext_req, 1'b0);
      chk1("t2_done_after", mem_done, !Wbuf);
      chk1("t2_busy_after", mem_busy, 1'b0);
      chk("t2_rdata_after", read_data, 32'hDEADBEEF);
      @(negedge CLK);
      chk1("t2_done_end", mem_done, 1'b0);

      // Back-to-back reads, second accepted in the DONE cycle of the first
      @(negedge CLK);
      rw_flag = 2'd1; addr = 32'h40;
      @(posedge CLK); #1;
      rw_flag = 2'd0; ext_ack = 1'b1; ext_rdata = 32'h1111_1111;
      @(negedge CLK);
      chk1("t3_req_a", ext_req, 1'b1);
      chk("t3_addr_a", ext_addr, 32'h40);
      @(posedge CLK); #1;
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t3_done_a", mem_done, 1'b1);
      chk("t3_rdata_a", read_data, 32'h1111_1111);
      chk1("t3_busy_a", mem_busy, 1'b0);
      rw_flag = 2'd1; addr = 32'h44;
      @(posedge CLK); #1;
      rw_flag = 2'd0; ext_ack = 1'b1; ext_rdata = 32'h2222_2222;
      @(negedge CLK);
      chk1("t3_req_b", ext_req, 1'b1);
      chk("t3_addr_b", ext_addr, 32'h44);
      chk1("t3_done_gap", mem_done, 1'b0);
      chk("t3_rdata_hold", read_data, 32'h1111_1111);
      @(posedge CLK); #1;
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t3_done_b", mem_done, 1'b1);
      chk("t3_rdata_b", read_data, 32'h2222_2222);
      @(negedge CLK);
      chk1("t3_done_end", mem_done, 1'b0);

      // Reset while in BUS with ack withheld
      @(negedge CLK);
      rw_flag = 2'd1; addr = 32'h300;
      @(posedge CLK); #1;
      rw_flag = 2'd0;
      @(negedge CLK);
      chk1("t4_req_pre", ext_req, 1'b1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk_reset_outputs("t4");
      @(negedge CLK);
      chk1("t4_req_post", ext_req, 1'b0);
      chk1("t4_done_post", mem_done, 1'b0);

      // rw_flag = 3 is idle
      @(negedge CLK);
      rw_flag = 2'd3; addr = 32'h500; write_data = 32'hFFFF_FFFF; write_mask = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk1("t5_req", ext_req, 1'b0);
         chk1("t5_done", mem_done, 1'b0);
         chk1("t5_busy", mem_busy, 1'b0);
      end
      rw_flag = 2'd0;
      exp_rd = 32'd0;

`ifdef DMEM_WBUF_EN
      // Posted write to 0x10 followed by a read of 0x10, both acks delayed two cycles
      @(negedge CLK);
      rw_flag = 2'd2; addr = 32'h10; write_data = 32'h5566_7788; write_mask = 4'hF;
      @(posedge CLK); #1;
      rw_flag = 2'd0;
      @(negedge CLK);
      chk1("t6_wdone_c1", mem_done, 1'b1);
      chk1("t6_busy_c1", mem_busy, 1'b0);
      chk1("t6_req_c1", ext_req, 1'b1);
      chk1("t6_we_c1", ext_we, 1'b1);
      chk("t6_addr_c1", ext_addr, 32'h10);
      rw_flag = 2'd1; addr = 32'h10;
      @(posedge CLK); #1;
      rw_flag = 2'd0;
      @(negedge CLK);
      chk1("t6_busy_c2", mem_busy, 1'b1);
      chk1("t6_done_c2", mem_done, 1'b0);
      chk1("t6_we_c2", ext_we, 1'b1);
      @(posedge CLK); #1;
      ext_ack = 1'b1;
      @(negedge CLK);
      chk1("t6_req_c3", ext_req, 1'b1);
      @(posedge CLK); #1;
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t6_req_c4", ext_req, 1'b0);
      chk1("t6_busy_c4", mem_busy, 1'b1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk1("t6_req_c5", ext_req, 1'b1);
      chk1("t6_we_c5", ext_we, 1'b0);
      chk("t6_addr_c5", ext_addr, 32'h10);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk1("t6_done_c6", mem_done, 1'b0);
      @(posedge CLK); #1;
      ext_ack = 1'b1; ext_rdata = 32'h5566_7788;
      @(negedge CLK);
      chk1("t6_req_c7", ext_req, 1'b1);
      @(posedge CLK); #1;
      ext_ack = 1'b0;
      @(negedge CLK);
      chk1("t6_rdone_c8", mem_done, 1'b1);
      chk("t6_rdata_c8", read_data, 32'h5566_7788);
      chk1("t6_busy_c8", mem_busy, 1'b0);
      exp_rd = 32'h5566_7788;
`endif

      // Randomized requests against a program-order memory model
      @(negedge CLK);
      auto_ack = 1'b1;
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 2);
         for (int g = 0; g < k; g++) begin
            rw_flag = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            @(negedge CLK);
            chk1("rnd_idle_done", mem_done, 1'b0);
         end
         k = 0;
         while (mem_busy && k < 50) begin
            @(negedge CLK);
            k++;
         end
         chk1("rnd_busy_timeout", mem_busy, 1'b0);
         wr = ($urandom_range(0, 1) != 0);
         a  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
         d  = $urandom;
         m  = 4'($urandom_range(0, 15));
         rw_flag = wr ? 2'd2 : 2'd1; addr = a; write_data = d; write_mask = m;
         @(posedge CLK); #1;
         rw_flag = 2'd0;
         if (wr) gold_mem[a] = merge(rd_gold(a), d, m);
         else exp_rd = rd_gold(a);
         k = 0;
         @(negedge CLK);
         while (!mem_done && k < 40) begin
            @(negedge CLK);
            k++;
         end
         chk1("rnd_done_seen", mem_done, 1'b1);
         chk("rnd_rdata", read_data, exp_rd);
         chk1("rnd_busy_at_done", mem_busy, 1'b0);
         @(negedge CLK);
         chk1("rnd_done_width", mem_done, 1'b0);
      end
      auto_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory port controller sitting directly downstream of the pipeline memory stage. It accepts that stage's `rw_flag`/`addr`/`write_data`/`write_mask` request, runs one transfer on a variable-latency req/ack data bus, and returns `mem_busy`, `mem_done` and `read_data` to the stage. An optional one-entry posted-write buffer lets stores retire before the bus acknowledges them.

## Interface
Parameters: none.

- `CLK` in, 1: the single clock; all state updates on its rising edge.
- `RST` in, 1: reset, synchronous and active-high.
- `rw_flag` in, 2: 0 = idle, 1 = read, 2 = write, 3 = treated as idle.
- `addr` in, 32: word address; bits [1:0] are already 0.
- `write_data` in, 32: byte-lane-aligned store data.
- `write_mask` in, 4: byte enables, bit0 = byte [7:0].
- `read_data` out, 32: last completed read word.
- `mem_busy` out, 1: request cannot be accepted this cycle.
- `mem_done` out, 1: one-cycle pulse, previous accepted request complete.
- `ext_req` out, 1: bus transfer request.
- `ext_we` out, 1: 1 = write transfer.
- `ext_addr` out, 32: transfer address.
- `ext_wdata` out, 32: transfer write data.
- `ext_wmask` out, 4: transfer byte enables.
- `ext_ack` in, 1: transfer completes in any cycle with `ext_req && ext_ack`.
- `ext_rdata` in, 32: valid when `ext_ack` is high on a read.

## Operation
- A request is accepted at a rising edge when `mem_busy == 0` and `rw_flag` is 1 or 2. The controller captures addr, data, mask and direction into the main slot.
- `mem_busy` is a function of registered state only. It never depends on `rw_flag`, which avoids a combinational loop through the memory stage.
- Main-slot FSM:
  - IDLE: busy = 0. Accept moves to WAIT if a drain is pending, else to BUS.
  - WAIT: busy = 1. Moves to BUS once the write buffer is empty.
  - BUS: busy = 1, `ext_req` = 1. Outputs come from the main slot. On ack, moves to DONE; a read also latches `ext_rdata` into `read_data`.
  - DONE: busy = 0, `mem_done` = 1. Can accept a new request (to BUS or WAIT); otherwise returns to IDLE.
- `ext_*` outputs are registered and held stable while `ext_req && !ext_ack`. `ext_req` is low for at least one cycle after each ack.
- `read_data` holds its value until the next read completes. Writes pulse `mem_done` but leave `read_data` unchanged.
- Reset: state IDLE, `mem_busy` = 0, `mem_done` = 0, `read_data` = 0, `ext_req` = 0, `ext_we` = 0, `ext_addr`/`ext_wdata` = 0, `ext_wmask` = 0, write buffer empty. A reset mid-transfer abandons the transfer: `ext_req` is low in the cycle after the reset edge, and any buffered write is discarded.

## Timing
- Read, ack in the first BUS cycle: accept at edge 0, BUS in cycle 1, DONE with `mem_done` in cycle 2. Minimum latency is 2 cycles, plus one cycle per wait state.
- Back-to-back requests: a request accepted in DONE has its `ext_req` high in the following cycle.
- `mem_done` is exactly one cycle wide per accepted request, in request order.
- `rw_flag` = 0 or 3 while not busy: no state change.

## Configuration
- `DMEM_WBUF_EN` defined:
  - A write accepted while the buffer is empty goes into the buffer instead of the main slot. `mem_done` pulses in the next cycle with `mem_busy` = 0, and the buffer drains on the bus independently.
  - Reads, and writes that arrive while the buffer is full, go to WAIT. This preserves program order.
  - Bus outputs come from the buffer while it is draining.
- `DMEM_WBUF_EN` undefined: no buffer, writes use the main-slot FSM like reads, and the WAIT state is unreachable.

## Test plan
- Read at 0x100, `ext_rdata` = 0xDEADBEEF, ack in first BUS cycle -> `ext_req` cycle 1, `mem_done` and `read_data` = 0xDEADBEEF in cycle 2, `mem_busy` high in cycle 1 only.
- Write 0x000000AB to 0x204 with mask 0001, ack delayed 3 cycles -> `ext_*` stable for 4 cycles, `mem_done` one cycle after ack, `read_data` unchanged.
- Read accepted in the DONE cycle of a previous read -> second `ext_req` the next cycle, two distinct `mem_done` pulses, `read_data` updated each time.
- Reset asserted mid-BUS with ack withheld -> `ext_req` = 0 and all outputs at reset values the cycle after the reset edge, no `mem_done`.
- With `DMEM_WBUF_EN`: write to 0x10 then read from 0x10 the next cycle, ack delayed 2 cycles -> write `mem_done` one cycle after accept, read waits until the write ack, read bus transfer follows, read `mem_done` after its ack.
- `rw_flag` = 3 for 5 cycles -> no `ext_req`, no `mem_done`, `mem_busy` = 0.
